// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_if
// Description : Bundles the keypad matrix lines and the entry outputs of the
//               keypad entry block.
//               master - the keypad_entry side (senses col, drives the rest)
//               slave  - the keypad / display / lock side
//   col[3:0]         column sense, active-low, pulled up
//   row[3:0]         row drive, exactly one bit low
//   big_bin[19:0]    packed 4-character display word, digit 3 in [19:15]
//   digit_count[2:0] digits currently entered, 0..4
//   entry_valid      one-cycle pulse on a complete submitted entry
//   entry_code[15:0] BCD of the last submitted entry
//   entry_err        one-cycle pulse on Enter with an incomplete entry
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [19:0] big_bin;
    logic [2:0]  digit_count;
    logic        entry_valid;
    logic [15:0] entry_code;
    logic        entry_err;

    modport master (
        input  col,
        output row, big_bin, digit_count, entry_valid, entry_code, entry_err
    );

    modport slave (
        output col,
        input  row, big_bin, digit_count, entry_valid, entry_code, entry_err
    );
endinterface
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry
// Description : Scans a 4x4 active-low matrix keypad one row per slot,
//               debounces press and release, and edits a 4-character entry
//               held as a packed display word. Enter with four digits issues
//               the entry as BCD; Enter with fewer pulses an error.
//   clk    system clock
//   reset  synchronous, active-low reset
//   kp     keypad_if.master (col in; row, big_bin, digit_count,
//          entry_valid, entry_code, entry_err out)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  wire logic clk,
    input  wire logic reset,
    keypad_if.master  kp
);

    localparam int c_SLOT_W = $clog2(SCAN_DIV);
    localparam int c_CNT_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [4:0]  c_BLANK     = 5'b10011;
    localparam logic [19:0] c_ALL_BLANK = {4{c_BLANK}};

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [3:0]          r_col_s1, r_cs;
    logic [c_SLOT_W-1:0] r_slot;
    logic [1:0]          r_row_idx, w_row_nxt;
    logic [1:0]          r_col_idx, w_col_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                w_sample;
    logic                w_accept;
    logic [1:0]          w_low_col;
    logic                w_col_low;

    logic [19:0] r_big_bin;
    logic [2:0]  r_count;
    logic        r_valid;
    logic        r_err;
    logic [15:0] r_code;

    logic        w_is_digit, w_is_back, w_is_clear, w_is_enter;
    logic [3:0]  w_digit;

    // Column sync, slot timer and the scan/debounce state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col_s1  <= 4'hF;
            r_cs      <= 4'hF;
            r_slot    <= '0;
            r_state   <= ST_SCAN;
            r_row_idx <= 2'd0;
            r_col_idx <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_col_s1  <= kp.col;
            r_cs      <= r_col_s1;
            r_slot    <= w_sample ? '0 : r_slot + c_SLOT_W'(1);
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_nxt;
            r_col_idx <= w_col_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // The synchronized columns only settle late in a slot, so decisions are
    // taken on its last cycle.
    assign w_sample  = (r_slot == c_SLOT_LAST);
    assign w_col_low = ~r_cs[r_col_idx];

    always_comb begin
        w_low_col = 2'd3;
        if (!r_cs[0])      w_low_col = 2'd0;
        else if (!r_cs[1]) w_low_col = 2'd1;
        else if (!r_cs[2]) w_low_col = 2'd2;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_idx;
        w_col_nxt   = r_col_idx;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_SCAN: begin
                    if (r_cs != 4'hF) begin
                        w_col_nxt   = w_low_col;
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_row_nxt = r_row_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_col_low) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_accept    = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_row_nxt   = r_row_idx + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (r_cs == 4'hF) begin
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (r_cs == 4'hF) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_SCAN;
                            w_row_nxt   = r_row_idx + 2'd1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_HELD;
                    end
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    // Key decode from the latched row/column position
    always_comb begin
        w_is_digit = 1'b0;
        w_is_back  = 1'b0;
        w_is_clear = 1'b0;
        w_is_enter = 1'b0;
        w_digit    = 4'd0;
        case ({r_row_idx, r_col_idx})
            4'h0: begin w_is_digit = 1'b1; w_digit = 4'd1; end
            4'h1: begin w_is_digit = 1'b1; w_digit = 4'd2; end
            4'h2: begin w_is_digit = 1'b1; w_digit = 4'd3; end
            4'h3: w_is_back = 1'b1;
            4'h4: begin w_is_digit = 1'b1; w_digit = 4'd4; end
            4'h5: begin w_is_digit = 1'b1; w_digit = 4'd5; end
            4'h6: begin w_is_digit = 1'b1; w_digit = 4'd6; end
            4'h8: begin w_is_digit = 1'b1; w_digit = 4'd7; end
            4'h9: begin w_is_digit = 1'b1; w_digit = 4'd8; end
            4'hA: begin w_is_digit = 1'b1; w_digit = 4'd9; end
            4'hC: w_is_clear = 1'b1;
            4'hD: begin w_is_digit = 1'b1; w_digit = 4'd0; end
            4'hE: w_is_enter = 1'b1;
            default: ;
        endcase
    end

    // Entry editing, applied on the edge that ends the accepting sample
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_big_bin <= c_ALL_BLANK;
            r_count   <= 3'd0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= 16'h0000;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                if (w_is_digit) begin
                    r_big_bin <= {r_big_bin[14:0], 1'b0, w_digit};
                    if (r_count != 3'd4) r_count <= r_count + 3'd1;
                end else if (w_is_back) begin
                    if (r_count != 3'd0) begin
                        r_big_bin <= {c_BLANK, r_big_bin[19:5]};
                        r_count   <= r_count - 3'd1;
                    end
                end else if (w_is_clear) begin
                    r_big_bin <= c_ALL_BLANK;
                    r_count   <= 3'd0;
                end else if (w_is_enter) begin
                    if (r_count == 3'd4) begin
                        // Digits are codes 0..9, so the low nibble of each
                        // character is its BCD value.
                        r_code    <= {r_big_bin[18:15], r_big_bin[13:10],
                                      r_big_bin[8:5],   r_big_bin[3:0]};
                        r_valid   <= 1'b1;
                        r_big_bin <= c_ALL_BLANK;
                        r_count   <= 3'd0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign kp.row         = ~(4'b0001 << r_row_idx);
    assign kp.big_bin     = r_big_bin;
    assign kp.digit_count = r_count;
    assign kp.entry_valid = r_valid;
    assign kp.entry_code  = r_code;
    assign kp.entry_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry
// Description : Directed bench for keypad_entry (SCAN_DIV=4, DEBOUNCE_CNT=3).
//               A keypad model pulls columns low for pressed keys on the
//               currently driven row; a vector table drives key presses and
//               lists the expected entry state after each.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    localparam logic [4:0]  BL  = 5'h13;
    localparam logic [19:0] ABL = 20'h9CE73;

    logic        clk;
    logic        reset;
    logic [15:0] keys;      // bit r*4+c set = key at row r, column c held

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    keypad_if u_if();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .kp    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        u_if.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !u_if.row[r]) u_if.col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (u_if.entry_valid === 1'b1) n_valid++;
        if (u_if.entry_err === 1'b1)   n_err++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input int r, input int c);
        keys = 16'h0001 << (r*4 + c);
        repeat (120) @(negedge clk);
        keys = 16'h0000;
        repeat (60) @(negedge clk);
    endtask

    typedef struct {
        int          r;
        int          c;
        logic [19:0] bb;
        logic [2:0]  cnt;
        int          nv;
        int          ne;
        logic [15:0] code;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int v0, e0;
        logic [3:0] prev_row;
        bit found;

        tbl[0]  = '{1, 1, {BL, BL, BL, 5'd5},      3'd1, 0, 0, 16'h0000};
        tbl[1]  = '{3, 1, {BL, BL, 5'd5, 5'd0},    3'd2, 0, 0, 16'h0000};
        tbl[2]  = '{0, 1, {BL, 5'd5, 5'd0, 5'd2},  3'd3, 0, 0, 16'h0000};
        tbl[3]  = '{2, 0, {5'd5, 5'd0, 5'd2, 5'd7}, 3'd4, 0, 0, 16'h0000};
        tbl[4]  = '{3, 2, ABL,                     3'd0, 1, 0, 16'h5027};
        tbl[5]  = '{0, 0, {BL, BL, BL, 5'd1},      3'd1, 0, 0, 16'h5027};
        tbl[6]  = '{0, 1, {BL, BL, 5'd1, 5'd2},    3'd2, 0, 0, 16'h5027};
        tbl[7]  = '{3, 2, {BL, BL, 5'd1, 5'd2},    3'd2, 0, 1, 16'h5027};
        tbl[8]  = '{0, 3, {BL, BL, BL, 5'd1},      3'd1, 0, 0, 16'h5027};
        tbl[9]  = '{3, 0, ABL,                     3'd0, 0, 0, 16'h5027};
        tbl[10] = '{0, 3, ABL,                     3'd0, 0, 0, 16'h5027};
        tbl[11] = '{0, 0, {BL, BL, BL, 5'd1},      3'd1, 0, 0, 16'h5027};
        tbl[12] = '{0, 1, {BL, BL, 5'd1, 5'd2},    3'd2, 0, 0, 16'h5027};
        tbl[13] = '{0, 2, {BL, 5'd1, 5'd2, 5'd3},  3'd3, 0, 0, 16'h5027};
        tbl[14] = '{1, 0, {5'd1, 5'd2, 5'd3, 5'd4}, 3'd4, 0, 0, 16'h5027};
        tbl[15] = '{1, 1, {5'd2, 5'd3, 5'd4, 5'd5}, 3'd4, 0, 0, 16'h5027};
        tbl[16] = '{1, 3, {5'd2, 5'd3, 5'd4, 5'd5}, 3'd4, 0, 0, 16'h5027};
        tbl[17] = '{3, 0, ABL,                     3'd0, 0, 0, 16'h5027};

        keys  = 16'h0000;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_row",   {28'd0, u_if.row}, 32'hE);
        check("rst_bb",    {12'd0, u_if.big_bin}, {12'd0, ABL});
        check("rst_cnt",   {29'd0, u_if.digit_count}, 32'd0);
        check("rst_code",  {16'd0, u_if.entry_code}, 32'd0);
        check("rst_pulse", {30'd0, u_if.entry_valid, u_if.entry_err}, 32'd0);

        // Idle scan: each row low for 4 cycles in order
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan_row%0d", i), {28'd0, u_if.row},
                  {28'd0, ~(4'b0001 << (i / 4))});
            @(negedge clk);
        end
        check("idle_bb", {12'd0, u_if.big_bin}, {12'd0, ABL});
        check("idle_pulses", n_valid + n_err, 0);

        // Table of single-key presses
        for (int i = 0; i < 18; i++) begin
            v0 = n_valid;
            e0 = n_err;
            press(tbl[i].r, tbl[i].c);
            check($sformatf("v%0d_bb", i), {12'd0, u_if.big_bin}, {12'd0, tbl[i].bb});
            check($sformatf("v%0d_cnt", i), {29'd0, u_if.digit_count}, {29'd0, tbl[i].cnt});
            check($sformatf("v%0d_valid", i), n_valid - v0, tbl[i].nv);
            check($sformatf("v%0d_err", i), n_err - e0, tbl[i].ne);
            check($sformatf("v%0d_code", i), {16'd0, u_if.entry_code}, {16'd0, tbl[i].code});
        end

        // Bounce: two low samples then high must not accept
        found = 1'b0;
        prev_row = u_if.row;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (u_if.row == 4'b1110 && prev_row != 4'b1110) found = 1'b1;
            prev_row = u_if.row;
        end
        check("bounce_row0_seen", {31'd0, found}, 32'd1);
        keys = 16'h0001;
        repeat (8) @(negedge clk);
        keys = 16'h0000;
        repeat (40) @(negedge clk);
        check("bounce_no_accept", {29'd0, u_if.digit_count}, 32'd0);
        press(0, 0);
        check("bounce_cnt", {29'd0, u_if.digit_count}, 32'd1);
        check("bounce_bb", {12'd0, u_if.big_bin}, {12'd0, BL, BL, BL, 5'd1});

        // Reset while a key is held, then re-acceptance as a fresh press
        keys = 16'h0004;   // r0 c2 = '3'
        repeat (80) @(negedge clk);
        check("hold_cnt", {29'd0, u_if.digit_count}, 32'd2);
        check("hold_bb", {12'd0, u_if.big_bin}, {12'd0, BL, BL, 5'd1, 5'd3});
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_row",  {28'd0, u_if.row}, 32'hE);
        check("mid_rst_bb",   {12'd0, u_if.big_bin}, {12'd0, ABL});
        check("mid_rst_cnt",  {29'd0, u_if.digit_count}, 32'd0);
        check("mid_rst_code", {16'd0, u_if.entry_code}, 32'd0);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check("reaccept_cnt", {29'd0, u_if.digit_count}, 32'd1);
        check("reaccept_bb", {12'd0, u_if.big_bin}, {12'd0, BL, BL, BL, 5'd3});
        keys = 16'h0000;
        repeat (60) @(negedge clk);

        // Two keys on one row: lowest column wins ('2' over 'A')
        keys = 16'h000A;
        repeat (120) @(negedge clk);
        keys = 16'h0000;
        repeat (60) @(negedge clk);
        check("multi_cnt", {29'd0, u_if.digit_count}, 32'd2);
        check("multi_bb", {12'd0, u_if.big_bin}, {12'd0, BL, BL, 5'd3, 5'd2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces presses, and builds a 4-digit entry as a 20-bit packed display word using the same 5-bit character codes the seven-segment driver consumes. `big_bin` connects directly to the display driver's `big_bin` input, so the display echoes keystrokes. On Enter, the block issues the 4-digit code as BCD to the lock/control logic.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven. Must be ≥ 4.
- DEBOUNCE_CNT, 20: consecutive matching samples needed to accept a press or a release. Must be ≥ 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- col  in  4  keypad column sense. Active-low, externally pulled up. Asynchronous input.
- row  out  4  keypad row drive. Exactly one bit is low at a time.
- big_bin  out  20  packed display word. Digit 3 is in [19:15]; digit 0 is in [4:0].
- digit_count  out  3  number of digits entered, 0..4.
- entry_valid  out  1  one-cycle pulse when a complete entry is submitted.
- entry_code  out  16  BCD of the submitted entry, digit 3 in [15:12]. Holds its value until the next valid entry.
- entry_err  out  1  one-cycle pulse when Enter is pressed with an incomplete entry.

## Operation
- **Input sync:** `col` passes through a 2-flop synchronizer. All logic uses the synchronized value (`cs`).
- **Key map** (row r drives `row[r]` low; column c reads `col[c]`):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
- **Character codes:** digits 0–9 map to 5'b00000–5'b01001. Blank is 5'b10011.
- **Row slot:** a slot counter runs 0..SCAN_DIV-1. `cs` is sampled only on the last cycle of each slot.
- **State machine** (states SCAN, DEBOUNCE, HELD, RELEASE):
  - **SCAN:** rows rotate 0→1→2→3→0, one row per slot. At a sample, if `cs` ≠ 4'b1111, latch the row and the lowest-index low column, set the match count to 1, and go to DEBOUNCE. The row stays driven.
  - **DEBOUNCE:** at each sample, if the latched column is still low, increment the match count. When the count reaches DEBOUNCE_CNT, the key is accepted and the FSM goes to HELD. If the latched column is high, return to SCAN and advance to the next row. Changes on other columns are ignored.
  - **HELD:** the latched row stays driven. At the first sample with `cs` = 4'b1111, set the release count to 1 and go to RELEASE.
  - **RELEASE:** each all-high sample increments the release count. At DEBOUNCE_CNT, go to SCAN and advance to the next row. Any low column returns the FSM to HELD. There is no auto-repeat.
- **Actions on acceptance** (one cycle, registered):
  - **Digit:** `big_bin` ← {`big_bin[14:0]`, code}. `digit_count` increments and saturates at 4. A 5th digit shifts the oldest digit out.
  - **A (backspace):** `big_bin` ← {5'b10011, `big_bin[19:5]`}. `digit_count` decrements with a floor of 0. At 0 the word is unchanged.
  - **\* (clear):** `big_bin` ← all blank. `digit_count` ← 0.
  - **# (enter), `digit_count` == 4:** `entry_code` ← `big_bin` fields [18:15], [13:10], [8:5], [3:0]. `entry_valid` pulses. `big_bin` ← all blank. `digit_count` ← 0.
  - **# (enter), `digit_count` < 4:** `entry_err` pulses. No other change.
  - **B, C, D:** no action. These keys are still debounced and held.

## Timing
- **Reset values** (`reset` low at a clock edge):
  - `row` = 4'b1110
  - `big_bin` = 20'b10011_10011_10011_10011
  - `digit_count` = 0
  - `entry_valid` = 0, `entry_err` = 0
  - `entry_code` = 16'h0000
  - FSM state SCAN, slot and match counters 0, synchronizer flops 1
- **Reset mid-operation:** reset aborts any in-progress debounce or hold. A key still held after reset is detected and accepted again, as a fresh press.
- **Action latency:** outputs update on the clock edge after the accepting sample cycle. `entry_valid` and `entry_err` are high for exactly that one cycle.
- **Minimum press:** a press is accepted only if the column stays low for DEBOUNCE_CNT consecutive samples, i.e. about DEBOUNCE_CNT × SCAN_DIV cycles plus 2 synchronizer cycles.
- **Row settle:** the row changes at the start of a slot. The first valid synchronized sample comes at least SCAN_DIV-1 cycles later.
- **Multiple keys:**
  - Same row: the lowest column wins.
  - Different rows: the row scanned first wins.
  - A second key pressed during HELD is ignored until full release.

## Test plan
SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset, hold `col` = 4'b1111 → `row` cycles 1110, 1101, 1011, 0111, each for 4 cycles. `big_bin` = 20'h9CE73. No pulses.
2. Press '5' (r1, c1) for 20 samples then release; press '0', '2', '7' the same way → `big_bin` = {00101, 00000, 00010, 00111}, `digit_count` = 4. Each key produces exactly one update.
3. With "5027" entered, press '#' → `entry_valid` is one cycle high, `entry_code` = 16'h5027, `big_bin` = all blank, `digit_count` = 0.
4. Enter "12", press '#' → one-cycle `entry_err`, `big_bin` unchanged. Press 'A' → `big_bin[4:0]` = 00001, `digit_count` = 1. Press '\*' → all blank, `digit_count` = 0.
5. Bounce: pull the column low for 2 samples, high for 1, then low for 3 → exactly one digit accepted, at the 3rd consecutive low sample. A 5-digit entry "12345" → `big_bin` = {00010, 00011, 00100, 00101}, `digit_count` = 4.
6. Assert `reset` while in HELD with the key still down → reset values on the next edge. The key is re-accepted after 3 samples. Pressing c1 and c3 together on row 0 → '2' accepted.
